logo_column_scanner: RTL and testbench

Column scanner that reads the 38-row logo bitmap ROM one column at a time and streams each column serially into an external LED shift-register chain (74HC595-style: data, shift clock, latch). It sits between the logo ROM (combinational, column index in, 38-bit column out) and the display pins. It walks columns 0..COLS-1 cyclically to produce the sweeping logo.

---
 rtl/logo_pkg.sv | 21 ++
 rtl/sclk_tick.sv | 35 +++
 rtl/logo_column_scanner.sv | 150 +++++++++++++++
 tb/tb_logo_column_scanner.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logo_pkg.sv
// Shared constants and state encoding for the logo column scanner, ROM wrapper and bench.
package logo_pkg;

    localparam int ROWS      = 38;
    localparam int COLS      = 251;
    localparam int COL_IDX_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_LATCH,
        ST_HOLD
    } scan_state_e;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sclk_tick.sv
// Phase timer: strobes on the last cycle of every SCLK_DIV-cycle phase while run is high.
module sclk_tick #(
    parameter int SCLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);
    import logo_pkg::*;

    localparam int CW = cw(SCLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    // Holding the counter preloaded while idle makes the first phase exactly SCLK_DIV long.
    always_comb begin
        tick  = run && (cnt_q == '0);
        cnt_d = cnt_q;
        if (!run || cnt_q == '0) begin
            cnt_d = CW'(SCLK_DIV - 1);
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/logo_column_scanner.sv
// Walks the logo ROM column by column and shifts each 38-bit column out MSB first
// to a 74HC595-style chain, latching after every column.
module logo_column_scanner #(
    parameter int COLS        = logo_pkg::COLS,
    parameter int ROWS        = logo_pkg::ROWS,
    parameter int SCLK_DIV    = 1,
    parameter int HOLD_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    output logic [9:0]      col_idx,
    input  logic [ROWS-1:0] col_data,
    output logic            sr_data,
    output logic            sr_clk,
    output logic            sr_latch,
    output logic            frame_start,
    output logic            busy
);
    import logo_pkg::*;

    localparam int CIW = cw(COLS);
    localparam int BW  = cw(ROWS);
    localparam int HW  = cw(HOLD_CYCLES);

    scan_state_e     state_q, state_d;
    logic [CIW-1:0]  col_q, col_d;
    logic [ROWS-1:0] shreg_q, shreg_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            phase_q, phase_d;
    logic            sr_data_q, sr_data_d;
    logic            sr_clk_q, sr_clk_d;
    logic            sr_latch_q, sr_latch_d;
    logic            frame_start_q, frame_start_d;
    logic            busy_q, busy_d;
    logic            tick;
    logic            do_adv;

    sclk_tick #(.SCLK_DIV(SCLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state_q == ST_SHIFT || state_q == ST_LATCH),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        hold_d  = hold_q;
        phase_d = phase_q;
        do_adv  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                col_d = '0;
                if (enable) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                shreg_d = col_data;
                bit_d   = '0;
                phase_d = 1'b0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        shreg_d = shreg_q << 1;
                        phase_d = 1'b0;
                        if (bit_q == BW'(ROWS - 1)) state_d = ST_LATCH;
                        else                         bit_d   = bit_q + 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    if (HOLD_CYCLES > 0) begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                    end else begin
                        do_adv = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) do_adv = 1'b1;
                else                                 hold_d = hold_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // enable only matters here, so a dropped enable still finishes the column.
        if (do_adv) begin
            col_d = (col_q == CIW'(COLS - 1)) ? '0 : col_q + 1'b1;
            if (enable) begin
                state_d = ST_FETCH;
            end else begin
                state_d = ST_IDLE;
                col_d   = '0;
            end
        end

        // Pins are decoded from the next state so they register in step with it.
        sr_data_d     = (state_d == ST_SHIFT) && shreg_d[ROWS-1];
        sr_clk_d      = (state_d == ST_SHIFT) && phase_d;
        sr_latch_d    = (state_d == ST_LATCH);
        frame_start_d = (state_d == ST_FETCH) && (col_d == '0);
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            shreg_q       <= '0;
            bit_q         <= '0;
            hold_q        <= '0;
            phase_q       <= 1'b0;
            sr_data_q     <= 1'b0;
            sr_clk_q      <= 1'b0;
            sr_latch_q    <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            shreg_q       <= shreg_d;
            bit_q         <= bit_d;
            hold_q        <= hold_d;
            phase_q       <= phase_d;
            sr_data_q     <= sr_data_d;
            sr_clk_q      <= sr_clk_d;
            sr_latch_q    <= sr_latch_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign col_idx     = COL_IDX_W'(col_q);
    assign sr_data     = sr_data_q;
    assign sr_clk      = sr_clk_q;
    assign sr_latch    = sr_latch_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_logo_column_scanner.sv
// Two scanner configurations driven from a bench ROM; a pin-level monitor rebuilds each
// shifted column and checks it against columns predicted from cycle arithmetic.
module tb_logo_column_scanner;

    localparam int R  = logo_pkg::ROWS;
    localparam int C0 = 251;
    localparam int D0 = 1;
    localparam int H0 = 2;
    localparam int C1 = 7;
    localparam int D1 = 3;
    localparam int H1 = 0;

    typedef struct {
        int         col;
        logic [R-1:0] data;
        int         lcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] en;
    logic [1:0][9:0] ci_w;
    logic [1:0][R-1:0] cd_w;
    logic [1:0] sr_data_w, sr_clk_w, sr_latch_w, fs_w, busy_w;

    logic [R-1:0] tbl [0:1023];
    bit rom_mode;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int tmo_cnt = 0;
    bit fin_req = 0;
    bit fin_ack = 0;
    exp_t q0[$];
    exp_t q1[$];
    localparam logic [R-1:0] ONE = 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cd_w[0] = rom_mode ? (ONE << (R - 1 - int'(ci_w[0]) % R)) : tbl[ci_w[0]];
    assign cd_w[1] = rom_mode ? (ONE << (R - 1 - int'(ci_w[1]) % R)) : tbl[ci_w[1]];

    logo_column_scanner #(.COLS(C0), .ROWS(R), .SCLK_DIV(D0), .HOLD_CYCLES(H0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .col_idx(ci_w[0]), .col_data(cd_w[0]),
        .sr_data(sr_data_w[0]), .sr_clk(sr_clk_w[0]), .sr_latch(sr_latch_w[0]),
        .frame_start(fs_w[0]), .busy(busy_w[0])
    );

    logo_column_scanner #(.COLS(C1), .ROWS(R), .SCLK_DIV(D1), .HOLD_CYCLES(H1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .col_idx(ci_w[1]), .col_data(cd_w[1]),
        .sr_data(sr_data_w[1]), .sr_clk(sr_clk_w[1]), .sr_latch(sr_latch_w[1]),
        .frame_start(fs_w[1]), .busy(busy_w[1])
    );

    function automatic int dv(input int i);  return (i == 0) ? D0 : D1; endfunction
    function automatic int hv(input int i);  return (i == 0) ? H0 : H1; endfunction
    function automatic int cols(input int i); return (i == 0) ? C0 : C1; endfunction
    function automatic int per(input int i);
        return 1 + 2 * dv(i) * R + dv(i) + hv(i);
    endfunction

    // Reference column: row r of the picture lands on serial bit r.
    function automatic logic [R-1:0] model_col(input int c);
        logic [R-1:0] v;
        if (rom_mode) begin
            v = '0;
            v[R - 1 - (c % R)] = 1'b1;
        end else begin
            v = tbl[c];
        end
        return v;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [1:0] p_clk = '0, p_latch = '0, p_data = '0, p_busy = '0;
    logic [R-1:0] acc [2];
    int nbits [2];
    int hi_run [2];
    int lat_run [2];
    int lat_cnt [2];
    int fs_prev [2];

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @cyc %0d: got %0h expected %0h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic pop(input int i, output exp_t e, output bit ok);
        ok = 0;
        if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1; end
        if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1; end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                chk("reset_pins", i, {ci_w[i], sr_data_w[i], sr_clk_w[i], sr_latch_w[i], fs_w[i], busy_w[i]}, 64'd0);
                acc[i] = '0; nbits[i] = 0; hi_run[i] = 0; lat_run[i] = 0; lat_cnt[i] = 0; fs_prev[i] = -1;
            end else begin
                if (!busy_w[i]) begin
                    chk("idle_pins", i, {ci_w[i], sr_data_w[i], sr_clk_w[i], sr_latch_w[i], fs_w[i]}, 64'd0);
                    fs_prev[i] = -1;
                end
                if (busy_w[i] && !p_busy[i])
                    chk("start_col0_frame_start", i, {fs_w[i], ci_w[i]}, {1'b1, 10'd0});
                if (fs_w[i]) begin
                    chk("frame_start_col", i, ci_w[i], 64'd0);
                    if (fs_prev[i] >= 0) begin
                        chk("frame_period", i, cyc - fs_prev[i], cols(i) * per(i));
                        chk("latches_per_frame", i, lat_cnt[i], cols(i));
                    end
                    fs_prev[i] = cyc;
                    lat_cnt[i] = 0;
                end
                if (sr_clk_w[i] && !p_clk[i]) begin
                    acc[i] = {acc[i][R-2:0], sr_data_w[i]};
                    nbits[i]++;
                end
                if (sr_clk_w[i] && p_clk[i] && sr_data_w[i] !== p_data[i])
                    chk("data_stable_while_sclk_high", i, sr_data_w[i], p_data[i]);
                if (sr_clk_w[i]) hi_run[i]++;
                else if (p_clk[i]) begin
                    chk("sclk_high_len", i, hi_run[i], dv(i));
                    hi_run[i] = 0;
                end
                if (sr_latch_w[i] && !p_latch[i]) begin
                    pop(i, e, ok);
                    if (!ok) chk("unexpected_latch", i, 1, 0);
                    else begin
                        chk("latch_cycle", i, cyc, e.lcyc);
                        chk("column_bits", i, acc[i], e.data);
                        chk("bit_count", i, nbits[i], R);
                        chk("col_idx", i, ci_w[i], e.col);
                    end
                    acc[i] = '0;
                    nbits[i] = 0;
                    lat_cnt[i]++;
                end
                if (sr_latch_w[i]) begin
                    lat_run[i]++;
                    chk("latch_pins_low", i, {sr_clk_w[i], sr_data_w[i]}, 64'd0);
                end else if (p_latch[i]) begin
                    chk("latch_len", i, lat_run[i], dv(i));
                    lat_run[i] = 0;
                end
            end
            p_clk[i] = sr_clk_w[i];
            p_latch[i] = sr_latch_w[i];
            p_data[i] = sr_data_w[i];
            p_busy[i] = busy_w[i];
        end
        if (fin_req && !fin_ack) begin
            chk("timeouts", 0, tmo_cnt, 0);
            chk("leftover_expected", 0, q0.size(), 0);
            chk("leftover_expected", 1, q1.size(), 0);
            fin_ack = 1;
        end
    end

    // ---------------- stimulus + model ----------------
    task automatic push(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_idle(input int i, input int bound);
        int t = 0;
        while (busy_w[i] && t < bound) begin
            @(negedge clk);
            t++;
        end
        if (busy_w[i]) tmo_cnt++;
    endtask

    // Enable stays high through cycle n0+(ncols-1)*P+extra, so exactly ncols columns run.
    task automatic session(input int i, input int ncols, input int extra_in);
        int p, n0, extra;
        exp_t e;
        p = per(i);
        extra = (extra_in < 0) ? int'($urandom_range(0, p - 1)) : extra_in;
        @(negedge clk);
        n0 = cyc;
        en[i] = 1'b1;
        for (int k = 0; k < ncols; k++) begin
            e.col  = k % cols(i);
            e.data = model_col(e.col);
            e.lcyc = n0 + 1 + k * p + 1 + 2 * dv(i) * R;
            push(i, e);
        end
        repeat ((ncols - 1) * p + extra + 1) @(negedge clk);
        en[i] = 1'b0;
        wait_idle(i, p + 10);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int p;
        rst_n = 1'b0;
        en = '0;
        rom_mode = 0;
        for (int c = 0; c < 1024; c++) tbl[c] = {6'($urandom), 32'($urandom)};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Random columns, random drop point of enable
        session(0, 1 + $urandom_range(0, 3), -1);
        // Drop enable inside the shift of column 5
        session(0, 6, 2 + $urandom_range(0, 60));
        session(0, 2, -1);
        // Walking-one ROM
        rom_mode = 1;
        session(0, 40, -1);
        rom_mode = 0;

        // Asynchronous reset in the middle of column 2's shift
        p = per(0);
        begin
            exp_t e;
            int n0;
            @(negedge clk);
            n0 = cyc;
            en[0] = 1'b1;
            for (int k = 0; k < 10; k++) begin
                e.col = k; e.data = model_col(k); e.lcyc = n0 + 1 + k * p + 1 + 2 * D0 * R;
                q0.push_back(e);
            end
            repeat (2 * p + 30) @(negedge clk);
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            en[0] = 1'b0;
            q0.delete();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (3 * p) @(negedge clk);
        end
        session(0, 2, -1);

        // Full frame plus wrap
        for (int c = 0; c < 1024; c++) tbl[c] = {6'($urandom), 32'($urandom)};
        session(0, C0 + 2, -1);

        // Slow shift clock, no hold
        session(1, 10, -1);
        rom_mode = 1;
        session(1, 8, -1);
        rom_mode = 0;

        fin_req = 1;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
